// File: rtl/moving_average_envelope.sv
// Boxcar moving-average envelope: rectify (or square when ENVELOPE_SQUARE_EN is defined),
// accumulate over a 2^LOG2_WINDOW ring, emit one decimated mean per DECIM samples.
module moving_average_envelope #(
    parameter int unsigned LOG2_WINDOW = 3,
    parameter int unsigned DECIM       = 1,
    parameter int unsigned FXP_BITS    = 12
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_data_tdata,
    input  logic        s_axis_data_tvalid,
    output logic        s_axis_data_tready,
    output logic [31:0] m_axis_data_tdata,
    output logic        m_axis_data_tvalid,
    input  logic        m_axis_data_tready
);

    localparam int unsigned WIN   = 1 << LOG2_WINDOW;
    localparam int unsigned ACC_W = 32 + LOG2_WINDOW;

    typedef enum logic {
        FILL,
        RUN
    } state_e;

    state_e                   state_q;
    logic [31:0]              ring_q [WIN];
    logic [LOG2_WINDOW-1:0]   wr_ptr_q;
    logic [LOG2_WINDOW-1:0]   fill_cnt_q;
    logic [7:0]               dec_cnt_q;
    logic [ACC_W-1:0]         acc_q;
    logic [31:0]              m_tdata_q;
    logic                     m_tvalid_q;

    logic [31:0]              rect_d;
    logic [ACC_W-1:0]         sum_d;
    logic [31:0]              env_d;
    logic                     emit_d;
    logic                     accept;

`ifdef ENVELOPE_SQUARE_EN
    logic signed [63:0]       sq_d;

    always_comb begin
        sq_d = ($signed(s_axis_data_tdata) * $signed(s_axis_data_tdata)) >>> FXP_BITS;
        if (sq_d > 64'sh0000_0000_7FFF_FFFF) begin
            rect_d = 32'h7FFF_FFFF;
        end else begin
            rect_d = sq_d[31:0];
        end
    end
`else
    always_comb begin
        if (s_axis_data_tdata == 32'h8000_0000) begin
            rect_d = 32'h7FFF_FFFF;
        end else if (s_axis_data_tdata[31]) begin
            rect_d = -s_axis_data_tdata;
        end else begin
            rect_d = s_axis_data_tdata;
        end
    end
`endif

    // acc always equals the ring sum, so the subtraction cannot underflow.
    always_comb begin
        sum_d  = acc_q + ACC_W'(rect_d) - ACC_W'(ring_q[wr_ptr_q]);
        env_d  = sum_d[ACC_W-1:LOG2_WINDOW];
        emit_d = (state_q == FILL) ? (fill_cnt_q == '1) : (dec_cnt_q == '0);
    end

    assign s_axis_data_tready = !m_tvalid_q || m_axis_data_tready;
    assign accept             = s_axis_data_tvalid && s_axis_data_tready;
    assign m_axis_data_tdata  = m_tdata_q;
    assign m_axis_data_tvalid = m_tvalid_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            dec_cnt_q  <= '0;
            acc_q      <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            for (int unsigned i = 0; i < WIN; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                acc_q            <= sum_d;
                ring_q[wr_ptr_q] <= rect_d;
                wr_ptr_q         <= wr_ptr_q + LOG2_WINDOW'(1);
                case (state_q)
                    FILL: begin
                        fill_cnt_q <= fill_cnt_q + LOG2_WINDOW'(1);
                        if (fill_cnt_q == '1) begin
                            state_q <= RUN;
                            // The window-completing sample is the dec_cnt==0 output.
                            dec_cnt_q <= (DECIM == 1) ? 8'd0 : 8'd1;
                        end
                    end
                    RUN: begin
                        dec_cnt_q <= (dec_cnt_q == 8'(DECIM - 1)) ? 8'd0 : dec_cnt_q + 8'd1;
                    end
                    default: state_q <= FILL;
                endcase
            end

            if (accept && emit_d) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= env_d;
            end else if (m_axis_data_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_moving_average_envelope.sv
// Directed self-checking bench for moving_average_envelope (default build, LOG2_WINDOW=3).
module tb_moving_average_envelope;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        s_tready4;
    logic [31:0] m_tdata4;
    logic        m_tvalid4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    moving_average_envelope #(.LOG2_WINDOW(3), .DECIM(1), .FXP_BITS(12)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready)
    );

    moving_average_envelope #(.LOG2_WINDOW(3), .DECIM(4), .FXP_BITS(12)) dut4 (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready4),
        .m_axis_data_tdata  (m_tdata4),
        .m_axis_data_tvalid (m_tvalid4),
        .m_axis_data_tready (m_tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] x);
        s_tdata  = x;
        s_tvalid = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("rst_s_tready", 32'(s_tready), 32'd1);
    endtask

    initial begin
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        aresetn  = 1'b0;
        #1;
        chk("por_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("por_m_tdata", m_tdata, 32'd0);
        chk("por_s_tready", 32'(s_tready), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Constant 0x1000: first 7 silent, then 0x1000 every sample.
        for (int k = 1; k <= 7; k++) begin
            send(32'h0000_1000);
            chk("const_fill_tvalid", 32'(m_tvalid), 32'd0);
        end
        for (int k = 8; k <= 12; k++) begin
            send(32'h0000_1000);
            chk("const_run_tvalid", 32'(m_tvalid), 32'd1);
            chk("const_run_tdata", m_tdata, 32'h0000_1000);
        end

        // Mid-stream reset with an output pending.
        m_tready = 1'b0;
        do_reset();
        m_tready = 1'b1;

        // Alternating +/-0x2000 refills the window from scratch.
        for (int k = 1; k <= 8; k++) begin
            send((k % 2) ? 32'h0000_2000 : 32'hFFFF_E000);
            if (k < 8) chk("alt_fill_tvalid", 32'(m_tvalid), 32'd0);
        end
        chk("alt_tvalid", 32'(m_tvalid), 32'd1);
        chk("alt_tdata", m_tdata, 32'h0000_2000);
        for (int k = 1; k <= 8; k++) begin
            send(32'h0);
            chk("slide_tvalid", 32'(m_tvalid), 32'd1);
            chk("slide_tdata", m_tdata, 32'((8 - k) * 32'h400));
        end

        // Most-negative input saturates.
        for (int k = 1; k <= 8; k++) send(32'h8000_0000);
        chk("sat_tvalid", 32'(m_tvalid), 32'd1);
        chk("sat_tdata", m_tdata, 32'h7FFF_FFFF);

        // Backpressure: pending 0x800 must hold, nothing consumed.
        do_reset();
        for (int k = 1; k <= 8; k++) send(32'h0000_0800);
        chk("bp_pre_tdata", m_tdata, 32'h0000_0800);
        m_tready = 1'b0;
        s_tdata  = 32'h0000_1800;
        #1;
        chk("bp_s_tready_low", 32'(s_tready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge aclk);
            #1;
            chk("bp_hold_tvalid", 32'(m_tvalid), 32'd1);
            chk("bp_hold_tdata", m_tdata, 32'h0000_0800);
            chk("bp_hold_s_tready", 32'(s_tready), 32'd0);
        end
        m_tready = 1'b1;
        #1;
        chk("bp_release_s_tready", 32'(s_tready), 32'd1);
        send(32'h0000_1800);
        chk("bp_after1_tdata", m_tdata, 32'h0000_0A00);
        send(32'h0000_1800);
        chk("bp_after2_tdata", m_tdata, 32'h0000_0C00);

        // Idle input: output retires, nothing else changes.
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        chk("idle_tvalid", 32'(m_tvalid), 32'd0);
        send(32'h0000_1800);
        chk("idle_resume_tdata", m_tdata, 32'h0000_0E00);

        // Ramp k*0x1000: mean of last 8 = (2k-7)*0x800.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            send(32'(k * 32'h1000));
            if (k < 8) begin
                chk("ramp_fill_tvalid", 32'(m_tvalid), 32'd0);
                chk("ramp4_fill_tvalid", 32'(m_tvalid4), 32'd0);
            end else begin
                chk("ramp_tdata", m_tdata, 32'((2 * k - 7) * 32'h800));
                if ((k - 8) % 4 == 0) begin
                    chk("dec4_tvalid", 32'(m_tvalid4), 32'd1);
                    chk("dec4_tdata", m_tdata4, 32'((2 * k - 7) * 32'h800));
                end else begin
                    chk("dec4_gap_tvalid", 32'(m_tvalid4), 32'd0);
                end
            end
        end
        chk("dec4_s_tready", 32'(s_tready4), 32'd1);
        s_tvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/moving_average_envelope.md
# moving_average_envelope

Streaming envelope extractor directly downstream of the incremental normalization stage in the HSS pipeline. It consumes the normalized Q(FXP_BITS) signal over AXI-Stream and rectifies each sample. It computes a boxcar moving average over a power-of-two window using a circular buffer and running accumulator. The decimated envelope goes to the segmentation logic.

## Interface
- LOG2_WINDOW, 3: window length is 2^LOG2_WINDOW samples; legal range 1..6.
- DECIM, 1: emit one output per DECIM accepted samples once the window is full; legal range 1..255.
- FXP_BITS, 12: fractional bits of input and output. Used only by the squaring path.
- aclk  input  1  single clock; all logic on rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- s_axis_data_tdata  input  32  signed normalized sample, Q(31-FXP_BITS).FXP_BITS.
- s_axis_data_tvalid  input  1  upstream sample valid.
- s_axis_data_tready  output  1  block can accept a sample this cycle.
- m_axis_data_tdata  output  32  signed envelope value, same Q format, always >= 0.
- m_axis_data_tvalid  output  1  envelope value valid.
- m_axis_data_tready  input  1  downstream accepts.

## Operation
- Rectify, default: r = |x|. An input of -2^31 saturates r to 0x7FFF_FFFF.
- Ring buffer: 2^LOG2_WINDOW entries of 32 bits, plus write pointer wr_ptr of LOG2_WINDOW bits. The pointer wraps modulo the window.
- Accumulator: acc is unsigned, 32+LOG2_WINDOW bits.
- On each accepted sample (s_tvalid && s_tready):
  - acc <= acc + r - buf[wr_ptr]
  - buf[wr_ptr] <= r
  - wr_ptr <= wr_ptr + 1
  - Envelope value = (acc + r - buf[wr_ptr]) >> LOG2_WINDOW. It always fits in 31 bits.
- State machine with two states, FILL and RUN:
  - FILL: fill_cnt counts accepted samples. No outputs are produced. When the 2^LOG2_WINDOW-th sample is accepted, move to RUN; that sample produces an output.
  - RUN: dec_cnt counts 0..DECIM-1. Output when dec_cnt==0, then dec_cnt wraps. The first RUN output is the window-completing sample.
- No other states exist. Only reset returns the block to FILL.

## Timing
- Reset values:
  - All ring entries, acc, wr_ptr, fill_cnt and dec_cnt are 0.
  - State is FILL.
  - m_axis_data_tdata = 0, m_axis_data_tvalid = 0.
- s_axis_data_tready = !m_axis_data_tvalid || m_axis_data_tready. This is combinational and reads 1 out of reset.
- Latency: a sample accepted on edge N that produces an output drives m_tvalid=1 with its value from edge N.
- m_tvalid/m_tdata hold stable until m_tready is sampled high.
- Simultaneous accept on both sides in the same cycle: the old output retires and the new output loads. Throughput is one sample per cycle.
- Accept of a non-output sample while m_tvalid=1 and m_tready=1: m_tvalid drops to 0 next cycle.
- Backpressure: while m_tvalid=1 and m_tready=0, s_tready=0. No sample is consumed and no state changes.
- s_tvalid low: no state change; the output register behaves as above.
- Reset asserted mid-stream: everything returns to reset values immediately, including a pending output, which is dropped. The window refills from scratch.

## Configuration
- ENVELOPE_SQUARE_EN:
  - When defined, rectification becomes energy: r = (x*x) >>> FXP_BITS. The 64-bit product is saturated to 0x7FFF_FFFF if the result exceeds 31 bits.
  - When undefined, r = |x| as above.
  - Ring, accumulator, FSM and handshake are identical in both builds.

## Test plan
- Reset/idle (defaults): assert aresetn=0 mid-stream -> m_tvalid=0 and m_tdata=0 immediately; s_tready=1 after release; the next 7 samples give no output.
- Constant fill (LOG2_WINDOW=3, DECIM=1): stream 0x1000 continuously -> samples 1-7 give no output; the 8th and every later sample give 0x0000_1000, one per cycle with m_tready=1.
- Rectify and window slide: feed 8×(+0x2000,-0x2000 alternating), then 8×0 -> output 0x2000 on sample 8. Over the zeros, outputs step 0x1C00, 0x1800 … 0x0400, 0x0000.
- Saturation: 8× 0x8000_0000 -> output 0x7FFF_FFFF. With ENVELOPE_SQUARE_EN, 8× 0x2000 -> 0x4000, and 8× 0x7FFF_FFFF -> 0x7FFF_FFFF.
- Backpressure: hold m_tready=0 for 5 cycles with an output pending -> m_tdata stable, s_tready=0, no input consumed. After release, the output sequence matches the unstalled reference with no loss or duplication.
- Decimation (DECIM=4): stream a ramp 1,2,3… (×0x1000) -> outputs only on samples 8, 12, 16, … with values equal to the mean of the last 8 samples (sample 8 -> 0x4800).
